// File: rtl/alu_cmd_scheduler.sv
// alu_cmd_scheduler: buffers ALU commands, issues one per cycle to a 1-cycle
// registered ALU, and returns tagged results through a credit-protected
// response queue so captures can never be dropped.
module alu_cmd_scheduler #(
   parameter int DEPTH     = 4,
   parameter int RSP_DEPTH = 3,
   parameter int TAG_W     = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [3:0]               cmd_a_i,
   input  logic [3:0]               cmd_b_i,
   input  logic [2:0]               cmd_sel_i,
   input  logic [TAG_W-1:0]         cmd_tag_i,
   output logic [3:0]               alu_a_o,
   output logic [3:0]               alu_b_o,
   output logic [2:0]               alu_sel_o,
   input  logic [4:0]               alu_result_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [4:0]               rsp_result_o,
   output logic [TAG_W-1:0]         rsp_tag_o,
   output logic                     rsp_dz_o,
   output logic [$clog2(DEPTH):0]   fifo_level_o
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CMD_W = 11 + TAG_W;
   localparam int RSP_W = 6 + TAG_W;
   localparam int RPW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int RCW   = $clog2(RSP_DEPTH + 1);
   localparam int CRW   = $clog2(RSP_DEPTH + 3);

   // command FIFO state
   logic [CMD_W-1:0] cmd_mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      cnt_q, cnt_d;
   logic             cmd_ready_q;
   logic [CMD_W-1:0] head;

   // pipeline tracking the ALU latency
   logic             s1_v_q, s2_v_q;
   logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
   logic             s1_dz_q, s2_dz_q;
   logic [3:0]       alu_a_q, alu_b_q;
   logic [2:0]       alu_sel_q;

   // response queue state
   logic [RSP_W-1:0] rsp_mem_q [RSP_DEPTH];
   logic [RPW-1:0]   rwr_q, rrd_q;
   logic [RCW-1:0]   rcnt_q;
   logic [RSP_W-1:0] rsp_head;

   logic             push, issue, rsp_pop, credit_ok, head_dz;
   logic [CRW-1:0]   credit_use;

   function automatic logic [RPW-1:0] rinc(input logic [RPW-1:0] p);
      return (p == RPW'(RSP_DEPTH - 1)) ? '0 : p + RPW'(1);
   endfunction

   assign push    = cmd_valid_i & cmd_ready_q;
   assign rsp_pop = rsp_valid_o & rsp_ready_i;
   assign head    = cmd_mem_q[rd_ptr_q];
   assign head_dz = (head[TAG_W+2:TAG_W+1] == 2'b11) && (head[TAG_W+6:TAG_W+3] == 4'd0);

   // Everything already committed to a response slot, net of this cycle's pop.
   assign credit_use = CRW'(s1_v_q) + CRW'(s2_v_q) + CRW'(rcnt_q) - CRW'(rsp_pop);
   assign credit_ok  = credit_use < CRW'(RSP_DEPTH);
   assign issue      = (cnt_q != '0) & credit_ok;
   assign cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(issue);

   // command storage; no reset needed, reads are guarded by the count
   always_ff @(posedge clk_i) begin
      if (push) cmd_mem_q[wr_ptr_q] <= {cmd_a_i, cmd_b_i, cmd_sel_i, cmd_tag_i};
   end

   // FIFO pointers, occupancy and registered ready
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
         if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q       <= cnt_d;
         cmd_ready_q <= cnt_d < (PW+1)'(DEPTH);
      end
   end

   // issue stage S1 drives the ALU; S2 waits out the ALU register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
         s1_v_q    <= 1'b0;
         s1_tag_q  <= '0;
         s1_dz_q   <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_tag_q  <= '0;
         s2_dz_q   <= 1'b0;
      end else begin
         if (issue) begin
            alu_a_q   <= head[TAG_W+10:TAG_W+7];
            alu_b_q   <= head[TAG_W+6:TAG_W+3];
            alu_sel_q <= head[TAG_W+2:TAG_W];
            s1_tag_q  <= head[TAG_W-1:0];
            s1_dz_q   <= head_dz;
         end
         s1_v_q   <= issue;
         s2_v_q   <= s1_v_q;
         s2_tag_q <= s1_tag_q;
         s2_dz_q  <= s1_dz_q;
      end
   end

   // response storage; divide-by-zero results are forced to zero at capture
   always_ff @(posedge clk_i) begin
      if (s2_v_q) rsp_mem_q[rwr_q] <= {(s2_dz_q ? 5'd0 : alu_result_i), s2_tag_q, s2_dz_q};
   end

   // response queue pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rwr_q  <= '0;
         rrd_q  <= '0;
         rcnt_q <= '0;
      end else begin
         if (s2_v_q)  rwr_q <= rinc(rwr_q);
         if (rsp_pop) rrd_q <= rinc(rrd_q);
         rcnt_q <= rcnt_q + RCW'(s2_v_q) - RCW'(rsp_pop);
      end
   end

   assign rsp_head     = rsp_mem_q[rrd_q];
   assign rsp_valid_o  = (rcnt_q != '0);
   assign rsp_result_o = rsp_valid_o ? rsp_head[RSP_W-1:TAG_W+1] : 5'd0;
   assign rsp_tag_o    = rsp_valid_o ? rsp_head[TAG_W:1] : '0;
   assign rsp_dz_o     = rsp_valid_o & rsp_head[0];

   assign cmd_ready_o  = cmd_ready_q;
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_sel_o    = alu_sel_q;
   assign fifo_level_o = cnt_q;

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Bench for alu_cmd_scheduler: directed scenarios plus a random phase, with a
// stub 1-cycle ALU and a queue-based scoreboard of expected responses.
module tb_alu_cmd_scheduler;

   typedef struct packed {
      logic [4:0] res;
      logic [3:0] tag;
      logic       dz;
   } rsp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [3:0] cmd_a, cmd_b;
   logic [2:0] cmd_sel;
   logic [3:0] cmd_tag;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_sel;
   logic [4:0] alu_result = 5'd0;
   logic       rsp_valid, rsp_ready;
   logic [4:0] rsp_result;
   logic [3:0] rsp_tag;
   logic       rsp_dz;
   logic [2:0] fifo_level;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   rsp_t exp_q[$];
   rsp_t got_q[$];
   int   pop_cyc[$];

   alu_cmd_scheduler #(.DEPTH(4), .RSP_DEPTH(3), .TAG_W(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_sel_i(cmd_sel), .cmd_tag_i(cmd_tag),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
      .alu_result_i(alu_result),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result), .rsp_tag_o(rsp_tag), .rsp_dz_o(rsp_dz),
      .fifo_level_o(fifo_level)
   );

   always #5 clk = ~clk;

   // Raw ALU behaviour; division by zero yields junk that the scheduler must mask.
   function automatic logic [4:0] alu_raw(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (sel)
         3'd0: r = ia + ib;
         3'd1: r = ia - ib;
         3'd2: r = ia * ib;
         3'd3: r = ia & ib;
         3'd4: r = ia | ib;
         3'd5: r = ia ^ ib;
         3'd6: r = (ib == 0) ? 31 : ia % ib;
         default: r = (ib == 0) ? 31 : ia / ib;
      endcase
      return 5'(r & 31);
   endfunction

   // stub ALU with one registered stage
   always @(posedge clk) alu_result <= alu_raw(alu_a, alu_b, alu_sel);

   function automatic rsp_t model(input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] sel, input logic [3:0] tag);
      rsp_t r;
      r.dz  = (sel >= 3'd6) && (b == 4'd0);
      r.res = r.dz ? 5'd0 : alu_raw(a, b, sel);
      r.tag = tag;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel, input logic [3:0] tag);
      cmd_valid = 1'b1;
      cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag;
   endtask

   // One clock: record handshakes due at the coming edge, then move to the next negedge.
   task automatic tick();
      rsp_t e;
      #1;
      if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_b, cmd_sel, cmd_tag));
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) chk("spurious_rsp", 32'(rsp_valid), 32'd0);
         else begin
            e = exp_q.pop_front();
            chk("rsp", 32'({rsp_result, rsp_tag, rsp_dz}), 32'(e));
            got_q.push_back(rsp_t'({rsp_result, rsp_tag, rsp_dz}));
            pop_cyc.push_back(cyc);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_level"}, 32'(fifo_level), 32'd0);
      chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_sel}), 32'd0);
      chk({tag, "_rsp"}, 32'({rsp_valid, rsp_result, rsp_tag, rsp_dz}), 32'd0);
   endtask

   initial begin
      int c0, acc;
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");

      // release: ready rises only after the first edge
      rst_n = 1'b1;
      #1 chk("ready_at_release", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_edge", 32'(cmd_ready), 32'd1);

      // single command latency
      put(4'd3, 4'd5, 3'd0, 4'd1);
      tick();
      cmd_valid = 1'b0;
      chk("lat_n0", 32'(rsp_valid), 32'd0);
      tick(); chk("lat_n1", 32'(rsp_valid), 32'd0);
      tick(); chk("lat_n2", 32'(rsp_valid), 32'd0);
      tick(); chk("lat_n3", 32'(rsp_valid), 32'd1);
      chk("lat_val", 32'({rsp_result, rsp_tag, rsp_dz}), 32'({5'd8, 4'd1, 1'b0}));
      drain();

      // back-to-back, full throughput
      got_q.delete(); pop_cyc.delete();
      rsp_ready = 1'b1;
      c0 = cyc;
      put(4'd1, 4'd2, 3'd0, 4'd2);    tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      put(4'd2, 4'd5, 3'd1, 4'd3);    tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      put(4'd15, 4'd15, 3'd2, 4'd4);  tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      put(4'd12, 4'd10, 3'd3, 4'd5);  tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      put(4'd12, 4'd3, 3'd4, 4'd6);   tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      put(4'd9, 4'd5, 3'd5, 4'd7);    tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      put(4'd13, 4'd4, 3'd6, 4'd8);   tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      put(4'd14, 4'd3, 3'd7, 4'd9);   tick(); chk("b2b_level", 32'(fifo_level), 32'd1);
      drain();
      chk("b2b_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < pop_cyc.size(); i++)
         chk("b2b_cycle", 32'(pop_cyc[i]), 32'(c0 + 4 + i));
      if (got_q.size() >= 3) begin
         chk("sub_2_5", 32'(got_q[1].res), 32'h1D);
         chk("mul_15_15", 32'(got_q[2].res), 32'h01);
      end

      // divide / modulo by zero
      got_q.delete();
      put(4'd7, 4'd0, 3'd7, 4'd10); tick();
      put(4'd5, 4'd0, 3'd6, 4'd11); tick();
      put(4'd9, 4'd2, 3'd7, 4'd12); tick();
      drain();
      chk("dz_count", 32'(got_q.size()), 32'd3);
      if (got_q.size() >= 3) begin
         chk("div0", 32'(got_q[0]), 32'({5'd0, 4'd10, 1'b1}));
         chk("mod0", 32'(got_q[1]), 32'({5'd0, 4'd11, 1'b1}));
         chk("div9_2", 32'(got_q[2]), 32'({5'd4, 4'd12, 1'b0}));
      end

      // backpressure: only 3 responses + 4 FIFO entries can be absorbed
      got_q.delete();
      rsp_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 20; k++) begin
         put(4'(acc), 4'(acc + 1), 3'd0, 4'(acc));
         if (cmd_ready) acc++;
         tick();
      end
      chk("bp_accepted", 32'(acc), 32'd7);
      chk("bp_level", 32'(fifo_level), 32'd4);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      drain();
      chk("bp_drained", 32'(got_q.size()), 32'd7);
      for (int i = 0; i < got_q.size(); i++) chk("bp_order", 32'(got_q[i].tag), 32'(i));

      // async reset with work queued and in flight
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin put(4'(k), 4'd1, 3'd0, 4'(k)); tick(); end
      cmd_valid = 1'b0;
      chk("pre_rst_level", 32'(fifo_level), 32'd2);
      chk("pre_rst_rsp", 32'(rsp_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
         chk("post_rst_level", 32'(fifo_level), 32'd0);
      end

      // random traffic against the scoreboard
      for (int k = 0; k < 400; k++) begin
         cmd_valid = ($urandom_range(0, 9) < 6);
         cmd_a     = 4'($urandom_range(0, 15));
         cmd_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         cmd_sel   = 3'($urandom_range(0, 7));
         cmd_tag   = 4'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
